// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_pkg
// Description : Shared constants, state encodings and helpers for crc_stream.
// Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

  localparam bit CRC_MODE_GEN   = 1'b0;
  localparam bit CRC_MODE_CHECK = 1'b1;

  typedef logic [0:0] gen_state_t;
  localparam gen_state_t GEN_PAYLOAD = 1'b0;
  localparam gen_state_t GEN_APPEND  = 1'b1;

  typedef logic [0:0] chk_state_t;
  localparam chk_state_t CHK_FILL   = 1'b0;
  localparam chk_state_t CHK_STREAM = 1'b1;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc_byte_step.sv
`default_nettype none
// ============================================================================
// Module      : crc_byte_step
// Description : Combinational one-byte CRC update, MSB-first, normal polynomial.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_byte_step #(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 'h07
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       data_in,
  output logic [CRC_W-1:0] crc_next
);

  logic [CRC_W-1:0] c_v;

  always_comb begin
    c_v = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c_v[CRC_W-1] ^ data_in[7-i]) c_v = {c_v[CRC_W-2:0], 1'b0} ^ POLY;
      else                             c_v = {c_v[CRC_W-2:0], 1'b0};
    end
    crc_next = c_v;
  end

endmodule
`default_nettype wire

// File: rtl/crc_stream.sv
`default_nettype none
// ============================================================================
// Module      : crc_stream
// Description : Byte-stream CRC engine; GEN appends the CRC, CHECK strips and
//               verifies it. Valid/ready on both sides, single output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_stream
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = 'h07,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter bit               REFLECT = 1'b0,
  parameter bit               MODE    = CRC_MODE_GEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             chk_valid,
  output logic             chk_ok,
  output logic             chk_short,
  output logic [CRC_W-1:0] crc_out
);

  localparam int         CRC_BYTES = CRC_W / 8;
  localparam logic [2:0] LAST_IDX  = 3'(CRC_BYTES - 1);
  localparam logic [2:0] FILL_END  = 3'(CRC_BYTES);

  gen_state_t gen_state_q, gen_state_d;
  chk_state_t chk_state_q, chk_state_d;
  logic [CRC_W-1:0] crc_q, crc_d, crc_out_q, crc_out_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CRC_BYTES-1:0][7:0] dl_q, dl_d, dl_shift;
  logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             chk_valid_q, chk_valid_d, chk_ok_q, chk_ok_d, chk_short_q, chk_short_d;
  logic             rdy_q, rdy_d;

  logic [7:0]       step_src, step_in;
  logic [CRC_W-1:0] crc_step, crc_final, recv;
  logic [2:0]       tx_idx;
  logic             out_free, in_append, s_fire;

  function automatic logic [CRC_W-1:0] bitrev_w(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [CRC_W-1:0] v, input logic [2:0] k);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < CRC_BYTES; i++) if (3'(i) == k) r = v[8*i +: 8];
    return r;
  endfunction

  // CHECK feeds the byte leaving the delay line; GEN feeds the byte arriving
  assign step_src = (MODE == CRC_MODE_CHECK) ? dl_q[0] : s_data;
  assign step_in  = REFLECT ? bitrev8(step_src) : step_src;

  crc_byte_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .crc_in   (crc_q),
    .data_in  (step_in),
    .crc_next (crc_step)
  );

  assign crc_final = (REFLECT ? bitrev_w(crc_step) : crc_step) ^ XOR_OUT;
  assign out_free  = !m_valid_q || m_ready;
  assign in_append = (MODE == CRC_MODE_GEN) && (gen_state_q == GEN_APPEND);
  assign s_ready   = rdy_q && out_free && !in_append;
  assign s_fire    = s_valid && s_ready;
  assign tx_idx    = REFLECT ? cnt_q : (LAST_IDX - cnt_q);

  // dl_shift[0] is the oldest byte; recv reassembles the trailer in wire order
  always_comb begin
    dl_shift = dl_q;
    for (int i = 0; i < CRC_BYTES - 1; i++) dl_shift[i] = dl_q[i+1];
    dl_shift[CRC_BYTES-1] = s_data;
    recv = '0;
    for (int i = 0; i < CRC_BYTES; i++) begin
      if (REFLECT) recv[8*i +: 8] = dl_shift[i];
      else         recv[8*(CRC_BYTES-1-i) +: 8] = dl_shift[i];
    end
  end

  always_comb begin
    gen_state_d = gen_state_q;
    chk_state_d = chk_state_q;
    crc_d       = crc_q;
    crc_out_d   = crc_out_q;
    cnt_d       = cnt_q;
    dl_d        = dl_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    chk_valid_d = 1'b0;
    chk_ok_d    = chk_ok_q;
    chk_short_d = chk_short_q;
    rdy_d       = 1'b1;

    if (abort) begin
      gen_state_d = GEN_PAYLOAD;
      chk_state_d = CHK_FILL;
      crc_d       = INIT;
      cnt_d       = '0;
      m_valid_d   = 1'b0;
    end else begin
      if (out_free) m_valid_d = 1'b0;
      if (MODE == CRC_MODE_GEN) begin
        if (gen_state_q == GEN_APPEND) begin
          if (out_free) begin
            m_valid_d = 1'b1;
            m_data_d  = pick_byte(crc_out_q, tx_idx);
            m_last_d  = (cnt_q == LAST_IDX);
            cnt_d     = cnt_q + 3'd1;
            if (cnt_q == LAST_IDX) begin
              gen_state_d = GEN_PAYLOAD;
              cnt_d       = '0;
            end
          end
        end else if (s_fire) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          m_last_d  = 1'b0;
          if (s_last) begin
            gen_state_d = GEN_APPEND;
            cnt_d       = '0;
            crc_d       = INIT;
            crc_out_d   = crc_final;
          end else begin
            crc_d = crc_step;
          end
        end
      end else if (s_fire) begin
        dl_d = dl_shift;
        if (chk_state_q == CHK_FILL) begin
          if (s_last) begin
            chk_valid_d = 1'b1;
            chk_ok_d    = 1'b0;
            chk_short_d = 1'b1;
            cnt_d       = '0;
            crc_d       = INIT;
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 == FILL_END) chk_state_d = CHK_STREAM;
          end
        end else begin
          m_valid_d = 1'b1;
          m_data_d  = dl_q[0];
          m_last_d  = s_last;
          if (s_last) begin
            chk_valid_d = 1'b1;
            chk_ok_d    = (recv == crc_final);
            chk_short_d = 1'b0;
            crc_out_d   = crc_final;
            crc_d       = INIT;
            cnt_d       = '0;
            chk_state_d = CHK_FILL;
          end else begin
            crc_d = crc_step;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_state_q <= GEN_PAYLOAD;
      chk_state_q <= CHK_FILL;
      crc_q       <= INIT;
      crc_out_q   <= '0;
      cnt_q       <= '0;
      dl_q        <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_ok_q    <= 1'b0;
      chk_short_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      gen_state_q <= gen_state_d;
      chk_state_q <= chk_state_d;
      crc_q       <= crc_d;
      crc_out_q   <= crc_out_d;
      cnt_q       <= cnt_d;
      dl_q        <= dl_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      chk_valid_q <= chk_valid_d;
      chk_ok_q    <= chk_ok_d;
      chk_short_q <= chk_short_d;
      rdy_q       <= rdy_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign chk_valid = (MODE == CRC_MODE_CHECK) && chk_valid_q;
  assign chk_ok    = chk_ok_q;
  assign chk_short = chk_short_q;
  assign crc_out   = crc_out_q;

endmodule
`default_nettype wire

// File: tb/tb_crc_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_stream
// Description : Scoreboard bench; three crc_stream instances (CRC-8 GEN,
//               CRC-16 GEN, CRC-32 CHECK) share stimulus, selected by sel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_stream;

  typedef struct packed {logic [7:0] data; logic last; logic [31:0] crc;} exp_t;
  typedef struct packed {logic ok; logic shrt; logic [31:0] crc;} vrd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, abort, s_valid, s_last, m_ready, bp_en;
  logic [7:0] s_data;
  logic [1:0] sel;

  logic        s_ready0, m_valid0, m_last0, chk_valid0, chk_ok0, chk_short0;
  logic        s_ready1, m_valid1, m_last1, chk_valid1, chk_ok1, chk_short1;
  logic        s_ready2, m_valid2, m_last2, chk_valid2, chk_ok2, chk_short2;
  logic [7:0]  m_data0, m_data1, m_data2, crc_out0;
  logic [15:0] crc_out1;
  logic [31:0] crc_out2;

  logic        cur_s_ready, cur_m_valid, cur_m_last, cur_chk_valid, cur_chk_ok, cur_chk_short;
  logic [7:0]  cur_m_data;
  logic [31:0] cur_crc_out;

  int n_err = 0;
  int n_chk = 0;
  int out_cnt = 0;
  exp_t exp_q[$];
  vrd_t vrd_q[$];

  crc_stream #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00),
               .REFLECT(1'b0), .MODE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .s_valid(s_valid && sel == 2'd0), .s_ready(s_ready0), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0),
    .chk_valid(chk_valid0), .chk_ok(chk_ok0), .chk_short(chk_short0), .crc_out(crc_out0));

  crc_stream #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000),
               .REFLECT(1'b0), .MODE(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .s_valid(s_valid && sel == 2'd1), .s_ready(s_ready1), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1),
    .chk_valid(chk_valid1), .chk_ok(chk_ok1), .chk_short(chk_short1), .crc_out(crc_out1));

  crc_stream #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
               .REFLECT(1'b1), .MODE(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .s_valid(s_valid && sel == 2'd2), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2),
    .chk_valid(chk_valid2), .chk_ok(chk_ok2), .chk_short(chk_short2), .crc_out(crc_out2));

  always_comb begin
    case (sel)
      2'd1: begin
        cur_s_ready = s_ready1; cur_m_valid = m_valid1; cur_m_data = m_data1; cur_m_last = m_last1;
        cur_chk_valid = chk_valid1; cur_chk_ok = chk_ok1; cur_chk_short = chk_short1;
        cur_crc_out = {16'h0, crc_out1};
      end
      2'd2: begin
        cur_s_ready = s_ready2; cur_m_valid = m_valid2; cur_m_data = m_data2; cur_m_last = m_last2;
        cur_chk_valid = chk_valid2; cur_chk_ok = chk_ok2; cur_chk_short = chk_short2;
        cur_crc_out = crc_out2;
      end
      default: begin
        cur_s_ready = s_ready0; cur_m_valid = m_valid0; cur_m_data = m_data0; cur_m_last = m_last0;
        cur_chk_valid = chk_valid0; cur_chk_ok = chk_ok0; cur_chk_short = chk_short0;
        cur_crc_out = {24'h0, crc_out0};
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-serial reference; the reflected form shifts right with the reversed polynomial
  function automatic logic [31:0] model_crc(input logic [7:0] d[$], input int n, input int w,
                                            input logic [31:0] poly, input logic [31:0] init,
                                            input logic [31:0] xo, input bit refl);
    logic [31:0] mask, c, rp;
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
    rp = '0;
    c  = '0;
    if (refl) begin
      for (int b = 0; b < w; b++) begin rp[b] = poly[w-1-b]; c[b] = init[w-1-b]; end
      for (int i = 0; i < n; i++) begin
        c = c ^ {24'h0, d[i]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
      end
    end else begin
      c = init;
      for (int i = 0; i < n; i++) begin
        c = c ^ ({24'h0, d[i]} << (w - 8));
        for (int b = 0; b < 8; b++) c = c[w-1] ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
      end
    end
    return (c ^ xo) & mask;
  endfunction

  function automatic logic [7:0] wire_byte(input logic [31:0] c, input int j, input int k, input bit refl);
    return refl ? c[8*j +: 8] : c[8*(k-1-j) +: 8];
  endfunction

  task automatic drive_byte(input logic [7:0] b, input logic last);
    int t;
    s_valid = 1'b1; s_data = b; s_last = last;
    t = 0;
    do begin @(negedge clk); t++; end while (!cur_s_ready && t < 300);
    if (!cur_s_ready) check("s_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d[$]);
    int w, k, n, np;
    logic [31:0] poly, init, xo, c;
    bit refl, chk, ok;
    case (sel)
      2'd1:    begin w = 16; poly = 32'h1021; init = 32'hFFFF; xo = 0; refl = 0; chk = 0; end
      2'd2:    begin w = 32; poly = 32'h04C11DB7; init = 32'hFFFFFFFF; xo = 32'hFFFFFFFF; refl = 1; chk = 1; end
      default: begin w = 8; poly = 32'h07; init = 0; xo = 0; refl = 0; chk = 0; end
    endcase
    k = w / 8;
    n = d.size();
    if (!chk) begin
      c = model_crc(d, n, w, poly, init, xo, refl);
      for (int i = 0; i < n; i++) exp_q.push_back('{d[i], 1'b0, 32'h0});
      for (int j = 0; j < k; j++) exp_q.push_back('{wire_byte(c, j, k, refl), j == k - 1, c});
    end else if (n <= k) begin
      vrd_q.push_back('{1'b0, 1'b1, 32'h0});
    end else begin
      np = n - k;
      c  = model_crc(d, np, w, poly, init, xo, refl);
      ok = 1'b1;
      for (int j = 0; j < k; j++) if (d[np+j] !== wire_byte(c, j, k, refl)) ok = 1'b0;
      for (int i = 0; i < np; i++) exp_q.push_back('{d[i], i == np - 1, c});
      vrd_q.push_back('{ok, 1'b0, c});
    end
    for (int i = 0; i < n; i++) drive_byte(d[i], i == n - 1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || vrd_q.size() != 0) && t < 500) begin @(posedge clk); t++; end
    check("drain", 32'(exp_q.size() + vrd_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Outputs are sampled on the falling edge, where a valid&ready pair commits next edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (cur_m_valid && m_ready) begin
        exp_t e;
        out_cnt++;
        if (exp_q.size() == 0) check("unexpected_byte", {24'h0, cur_m_data}, 32'hFFFFFFFF);
        else begin
          e = exp_q.pop_front();
          check("m_data", {24'h0, cur_m_data}, {24'h0, e.data});
          check("m_last", {31'h0, cur_m_last}, {31'h0, e.last});
          if (e.last) check("crc_out", cur_crc_out, e.crc);
        end
      end
      if (cur_chk_valid) begin
        vrd_t v;
        if (vrd_q.size() == 0) check("unexpected_verdict", 32'd1, 32'd0);
        else begin
          v = vrd_q.pop_front();
          check("chk_ok", {31'h0, cur_chk_ok}, {31'h0, v.ok});
          check("chk_short", {31'h0, cur_chk_short}, {31'h0, v.shrt});
          if (!v.shrt) check("chk_crc_out", cur_crc_out, v.crc);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_en) m_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] f_dig[$], f_tmp[$];
  int         cnt_before;

  initial begin
    rst_n = 1'b0; abort = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    m_ready = 1'b1; bp_en = 1'b0; sel = 2'd0;
    for (int i = 0; i < 9; i++) f_dig.push_back(8'h31 + 8'(i));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready0", {31'h0, s_ready0}, 32'd0);
    check("rst_s_ready2", {31'h0, s_ready2}, 32'd0);
    check("rst_m_valid2", {31'h0, m_valid2}, 32'd0);
    check("rst_chk", {29'h0, chk_valid2, chk_ok2, chk_short2}, 32'd0);
    check("rst_crc_out2", crc_out2, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_s_ready", {31'h0, s_ready0}, 32'd1);
    @(posedge clk); #1;

    // CRC-8 and CRC-16 generation of the check string
    sel = 2'd0; cnt_before = out_cnt;
    frame(f_dig); wait_drain();
    check("crc8_value", {24'h0, crc_out0}, 32'h000000F4);
    check("gen_byte_count", 32'(out_cnt - cnt_before), 32'd10);
    sel = 2'd1;
    frame(f_dig); wait_drain();
    check("crc16_value", {16'h0, crc_out1}, 32'h000029B1);

    // CRC-32 verify: good frame, corrupted frame, short frame
    sel = 2'd2;
    f_tmp = f_dig;
    f_tmp.push_back(8'h26); f_tmp.push_back(8'h39); f_tmp.push_back(8'hF4); f_tmp.push_back(8'hCB);
    frame(f_tmp); wait_drain();
    check("crc32_value", crc_out2, 32'hCBF43926);
    f_tmp[4] = f_tmp[4] ^ 8'h01;
    frame(f_tmp); wait_drain();
    f_tmp = '{8'hAA, 8'hBB, 8'hCC};
    cnt_before = out_cnt;
    frame(f_tmp); wait_drain();
    check("short_no_output", 32'(out_cnt - cnt_before), 32'd0);

    // Random backpressure with back-to-back frames
    bp_en = 1'b1;
    sel = 2'd0;
    frame(f_dig); f_tmp = '{8'h00, 8'hFF, 8'h5A}; frame(f_tmp); frame(f_dig);
    wait_drain();
    sel = 2'd1;
    frame(f_dig); frame(f_tmp);
    wait_drain();
    sel = 2'd2;
    f_tmp = f_dig;
    f_tmp.push_back(8'h26); f_tmp.push_back(8'h39); f_tmp.push_back(8'hF4); f_tmp.push_back(8'hCB);
    frame(f_tmp); frame(f_tmp);
    f_tmp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    frame(f_tmp);
    wait_drain();
    bp_en = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;

    // Abort mid-frame, then a clean frame
    sel = 2'd0;
    exp_q.push_back('{8'h31, 1'b0, 32'h0});
    exp_q.push_back('{8'h32, 1'b0, 32'h0});
    drive_byte(8'h31, 1'b0); drive_byte(8'h32, 1'b0);
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    wait_drain();
    frame(f_dig); wait_drain();
    check("abort_crc8", {24'h0, crc_out0}, 32'h000000F4);

    // Asynchronous reset while the GEN trailer is pending
    m_ready = 1'b0;
    drive_byte(8'h41, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", {31'h0, m_valid0}, 32'd0);
    check("arst_m_data_last", {23'h0, m_data0, m_last0}, 32'd0);
    check("arst_crc_out", {24'h0, crc_out0}, 32'd0);
    check("arst_s_ready", {31'h0, s_ready0}, 32'd0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
